// File: rtl/musicbox_pkg.sv
// Shared constants and FSM encodings for the music box record/playback slice.
package musicbox_pkg;

  localparam logic [4:0]  MS_RECORD       = 5'd4;
  localparam logic [4:0]  MS_PLAY         = 5'd5;
  localparam logic [7:0]  SAMPLE_MIDSCALE = 8'd128;
  localparam int unsigned SAMPLE_RATE_HZ  = 22050;
  localparam int unsigned RECORD_SECONDS  = 5;
  localparam int unsigned CNT_W           = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    PLAY    = 2'd2,
    DONE    = 2'd3
  } top_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2
  } req_state_e;

endpackage

// File: rtl/musicbox_sample_fifo.sv
// Small first-word-fall-through sample FIFO; pop_data always shows the head entry.
module musicbox_sample_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock_50Mhz,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign occupancy = count;
  assign pop_data  = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot being written, so push is legal even when full.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/musicbox_recording_playback.sv
// Playback stage: prefetches recorded 8-bit samples from SDRAM into a FIFO and
// emits one per sample_tick until the whole recording has been played.
module musicbox_recording_playback
  import musicbox_pkg::*;
#(
  parameter logic [4:0]  PLAY_STATE  = MS_PLAY,
  parameter int unsigned NUM_SAMPLES = SAMPLE_RATE_HZ * RECORD_SECONDS,
  parameter logic [24:0] BASE_ADDR   = 25'd0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clock_50Mhz,
  input  logic        reset_n,
  input  logic [4:0]  mainState,
  input  logic        sample_tick,
  output logic [7:0]  audio_sample,
  output logic        audio_valid,
  output logic        stateComplete,
  output logic [15:0] underrun_count,
  output logic [31:0] debugString,
  output logic [24:0] sdram_inputAddress,
  output logic [15:0] sdram_writeData,
  input  logic [15:0] sdram_readData,
  output logic        sdram_isWriting,
  output logic        sdram_inputValid,
  input  logic        sdram_outputValid,
  input  logic        sdram_recievedCommand,
  input  logic        sdram_isBusy
);

  localparam int unsigned      OCC_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  top_state_e       top_state, top_next;
  req_state_e       req_state, req_next;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] played_count;
  logic             discard;

  logic             active;
  logic             abort;
  logic             fetching;
  logic             issue_ok;
  logic             accept;
  logic             pop;
  logic             underrun_hit;
  logic             push;

  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic [OCC_W-1:0] fifo_occ;
  logic [7:0]       readdata_unused;

  assign readdata_unused = sdram_readData[15:8];

  assign active       = (mainState == PLAY_STATE);
  assign abort        = !active;
  assign fetching     = (top_state == PREFILL) || (top_state == PLAY);
  assign issue_ok     = fetching && active && (fetch_count < NUM_CNT) && !fifo_full && !sdram_isBusy;
  assign accept       = (req_state == R_ISSUE) && sdram_recievedCommand;
  assign pop          = (top_state == PLAY) && active && sample_tick && !fifo_empty;
  assign underrun_hit = (top_state == PLAY) && active && sample_tick && fifo_empty;
  assign push         = (req_state == R_WAIT) && sdram_outputValid && !discard && active;

  musicbox_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .clear       (abort),
    .push        (push),
    .push_data   (sdram_readData[7:0]),
    .pop         (pop),
    .pop_data    (fifo_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .occupancy   (fifo_occ)
  );

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      top_state <= IDLE;
      req_state <= R_IDLE;
    end else begin
      top_state <= top_next;
      req_state <= req_next;
    end
  end

  always_comb begin
    top_next = top_state;
    case (top_state)
      IDLE:    if (active) top_next = PREFILL;
      PREFILL: begin
        if (abort)                                  top_next = IDLE;
        else if (fifo_full || fetch_count == NUM_CNT) top_next = PLAY;
      end
      PLAY: begin
        if (abort)                                  top_next = IDLE;
        else if (pop && played_count == LAST_CNT)   top_next = DONE;
      end
      DONE:    if (abort) top_next = IDLE;
      default: top_next = IDLE;
    endcase
  end

  always_comb begin
    req_next = req_state;
    case (req_state)
      R_IDLE:  if (issue_ok)          req_next = R_ISSUE;
      R_ISSUE: if (accept)            req_next = R_WAIT;
      R_WAIT:  if (sdram_outputValid) req_next = R_IDLE;
      default: req_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count        <= '0;
      played_count       <= '0;
      underrun_count     <= '0;
      audio_sample       <= SAMPLE_MIDSCALE;
      audio_valid        <= 1'b0;
      sdram_inputAddress <= '0;
      discard            <= 1'b0;
    end else begin
      audio_valid <= pop;
      if (req_state == R_IDLE && issue_ok)
        sdram_inputAddress <= BASE_ADDR + 25'(fetch_count);
      // A read in flight at abort still finishes on the bus; its data is dropped.
      if (req_state == R_WAIT && sdram_outputValid)
        discard <= 1'b0;
      else if (abort && req_state != R_IDLE)
        discard <= 1'b1;
      if (abort) begin
        fetch_count    <= '0;
        played_count   <= '0;
        underrun_count <= '0;
        audio_sample   <= SAMPLE_MIDSCALE;
      end else begin
        if (accept && !discard)
          fetch_count <= fetch_count + CNT_W'(1);
        if (pop) begin
          played_count <= played_count + CNT_W'(1);
          audio_sample <= fifo_data;
        end
        if (underrun_hit && underrun_count != '1)
          underrun_count <= underrun_count + 16'd1;
      end
    end
  end

  assign stateComplete    = (top_state == DONE);
  assign sdram_inputValid = (req_state == R_ISSUE);
  assign sdram_writeData  = '0;
  assign sdram_isWriting  = 1'b0;
  assign debugString      = {played_count[15:0], 5'b0, 3'(fifo_occ), 3'b0, 5'(top_state)};

endmodule
